// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and helpers for the seven-segment display controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        MODE_HEX  = 2'b00,
        MODE_UDEC = 2'b01,
        MODE_SDEC = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_NEGATE = 2'b01,
        ST_SHIFT  = 2'b10,
        ST_RENDER = 2'b11
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Active-low g..a pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble: one input bit per cycle, VALUE_W shift cycles after start.
// done_o is high during the final shift cycle; bcd_o holds the result afterwards.
module bin2bcd_iter #(
    parameter int VALUE_W    = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [VALUE_W-1:0]        bin_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [4*NUM_DIGITS-1:0]   bcd_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (bcd_q[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            bin_d  = bin_i;
            bcd_d  = '0;
            cnt_d  = CNT_W'(VALUE_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
            bin_d  = {bin_q[VALUE_W-2:0], 1'b0};
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q != CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment controller: hex / unsigned / signed decimal with blanking, blink, dp.
// Latency load->seg_n: hex 2, unsigned VALUE_W+2, signed VALUE_W+3; loads while busy are dropped.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int VALUE_W    = 20,
    parameter int CLK_HZ     = 50000000,
    parameter int BLINK_HZ   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [VALUE_W-1:0]      value,
    input  logic [1:0]              mode,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [8*NUM_DIGITS-1:0] seg_n
);
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int BLINK_RAW  = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_PER  = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
    localparam int BCW        = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
    localparam logic [63:0] LIM_UDEC = pow10(NUM_DIGITS);
    localparam logic [63:0] LIM_SDEC = pow10(NUM_DIGITS - 1);

    state_e                 state_q, state_d;
    mode_e                  mode_q, in_mode;
    logic [VALUE_W-1:0]     val_q, mag, eng_bin;
    logic                   blz_q, neg_q, ovf_pend_q, overflow_q, done_q;
    logic                   eng_start, eng_busy, eng_done;
    logic [BCD_W-1:0]       bcd, hex_nib, nib_src;
    logic [8*NUM_DIGITS-1:0] image_q, render_img, base_img, seg_q, seg_d;
    logic [7:0]             glyph, byte_v;
    logic [BCW-1:0]         bcnt_q, bcnt_d;
    logic                   phase_on_q, phase_on_d;
    logic [63:0]            in_ext;
    int                     msd;

    assign in_mode = (mode == 2'b01) ? MODE_UDEC : (mode == 2'b10) ? MODE_SDEC : MODE_HEX;
    assign in_ext  = 64'(value);
    assign mag     = val_q[VALUE_W-1] ? -val_q : val_q;
    assign hex_nib = BCD_W'(val_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    case (in_mode)
                        MODE_HEX:  state_d = ST_RENDER;
                        MODE_UDEC: state_d = ST_SHIFT;
                        default:   state_d = ST_NEGATE;
                    endcase
                end
            end
            ST_NEGATE: state_d = ST_SHIFT;
            ST_SHIFT:  if (eng_done || !eng_busy) state_d = ST_RENDER;
            ST_RENDER: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        eng_start = ((state_q == ST_IDLE) && load && (in_mode == MODE_UDEC)) ||
                    (state_q == ST_NEGATE);
        eng_bin   = (state_q == ST_IDLE) ? value : mag;
    end

    bin2bcd_iter #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (reset_n),
        .start_i (eng_start),
        .bin_i   (eng_bin),
        .busy_o  (eng_busy),
        .done_o  (eng_done),
        .bcd_o   (bcd)
    );

    // Overflow is resolved early and held pending until the image is rendered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_q      <= '0;
            mode_q     <= MODE_HEX;
            blz_q      <= 1'b0;
            neg_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else if (state_q == ST_IDLE && load) begin
            val_q      <= value;
            mode_q     <= in_mode;
            blz_q      <= blank_lz;
            neg_q      <= 1'b0;
            ovf_pend_q <= (in_mode == MODE_UDEC) ? (in_ext >= LIM_UDEC)
                                                 : ((in_ext >> BCD_W) != 64'd0);
        end else if (state_q == ST_NEGATE) begin
            neg_q      <= val_q[VALUE_W-1];
            ovf_pend_q <= (64'(mag) >= LIM_SDEC);
        end
    end

    always_comb begin
        render_img = '0;
        glyph      = SEG_BLANK;
        msd        = 0;
        nib_src    = (mode_q == MODE_HEX) ? hex_nib : bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (nib_src[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            glyph = {1'b1, hex_to_seg(nib_src[4*i +: 4])};
            if (blz_q && i > msd) glyph = SEG_BLANK;
            if (mode_q == MODE_SDEC && neg_q &&
                ((blz_q && i == msd + 1) || (!blz_q && i == NUM_DIGITS - 1)))
                glyph = SEG_MINUS;
            if (ovf_pend_q && mode_q != MODE_HEX) glyph = SEG_MINUS;
            render_img[8*i +: 8] = glyph;
        end
    end

    // Masks are live: applied on every cycle to whichever image is current.
    always_comb begin
        seg_d    = '1;
        byte_v   = SEG_BLANK;
        base_img = (state_q == ST_RENDER) ? render_img : image_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            byte_v = base_img[8*i +: 8];
            if (dp_mask[i]) byte_v[7] = 1'b0;
            if (blink_mask[i] && !phase_on_q) byte_v = SEG_BLANK;
            seg_d[8*i +: 8] = byte_v;
        end
    end

    always_comb begin
        bcnt_d     = bcnt_q + BCW'(1);
        phase_on_d = phase_on_q;
        if (bcnt_q == BCW'(BLINK_PER - 1)) begin
            bcnt_d     = '0;
            phase_on_d = !phase_on_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            image_q    <= '1;
            seg_q      <= '1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcnt_q     <= '0;
            phase_on_q <= 1'b1;
        end else begin
            seg_q      <= seg_d;
            done_q     <= (state_q == ST_RENDER);
            bcnt_q     <= bcnt_d;
            phase_on_q <= phase_on_d;
            if (state_q == ST_RENDER) begin
                image_q    <= render_img;
                overflow_q <= ovf_pend_q;
            end
        end
    end

    assign seg_n    = seg_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
